// File: rtl/eq_seq_pkg.sv
// Shared types and constants for the sequential nibble-wise equality checker.
package eq_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/eq4.sv
// Single-nibble equality comparator; the only comparison logic in the design.
module eq4
  import eq_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                eq
);

  assign eq = (a == b);

endmodule

// File: rtl/eq_seq_ctrl.sv
// Compares two captured operands one nibble per cycle, LSB first, and reports
// equality plus the index of the first differing nibble.
module eq_seq_ctrl
  import eq_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]                    X,
  input  logic [NIBBLE_W*NIBBLES-1:0]                    Y,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           Z,
  output logic [((NIBBLES > 1) ? $clog2(NIBBLES) : 1)-1:0] mismatch_idx,
  output logic                                           busy
);

  localparam int unsigned DATA_W = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                z_q, z_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   x_sh, y_sh;
  logic                nib_eq;

  // Bring the nibble under test down to bit 0 of each operand.
  assign x_sh = x_q >> (32'(cnt_q) * NIBBLE_W);
  assign y_sh = y_q >> (32'(cnt_q) * NIBBLE_W);

  eq4 u_eq4 (
    .a  (x_sh[NIBBLE_W-1:0]),
    .b  (y_sh[NIBBLE_W-1:0]),
    .eq (nib_eq)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = X;
          y_d     = Y;
          cnt_d   = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (!nib_eq) begin
          z_d     = 1'b0;
          idx_d   = cnt_q;
          state_d = DONE;
        end else if (cnt_q == LAST_IDX) begin
          z_d     = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == CMP);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign Z            = z_q;
  assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// Scoreboard bench for eq_seq_ctrl (NIBBLES=4): driver pushes model results,
// a negedge monitor pops and checks result, latency and hold stability.
module tb_eq_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         Z;
  logic [1:0]   mismatch_idx;
  logic         busy;

  eq_seq_ctrl #(.NIBBLES(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .X            (X),
    .Y            (Y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Z            (Z),
    .mismatch_idx (mismatch_idx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic z;
    int   idx;
    int   lat;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: scan nibbles LSB-first; first difference decides everything.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.z = 1'b1; e.idx = 0; e.lat = N; e.acc = 0;
    for (int i = 0; i < N; i++) begin
      if (((a >> (4 * i)) & 16'hF) != ((b >> (4 * i)) & 16'hF)) begin
        e.z = 1'b0; e.idx = i; e.lat = i + 1;
        return e;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: on each out_valid rise, pop and compare; while held, check stability.
  logic       prev_ov = 1'b0;
  logic       held_z;
  logic [1:0] held_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("Z", int'(Z), int'(e.z));
          check("mismatch_idx", int'(mismatch_idx), e.idx);
          check("latency", edge_cnt - e.acc, e.lat);
        end
        held_z   = Z;
        held_idx = mismatch_idx;
      end else if (out_valid) begin
        check("hold_Z", int'(Z), int'(held_z));
        check("hold_idx", int'(mismatch_idx), int'(held_idx));
        check("hold_in_ready", int'(in_ready), 0);
      end
      prev_ov = out_valid;
    end
  end

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit stall_valid);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid  = 1'b1;
    X         = a;
    Y         = b;
    out_ready = (hold == 0);
    @(negedge clk);
    e = model(a, b);
    e.acc = edge_cnt;
    sb.push_back(e);
    // Operand lines and in_valid wander after the accept edge.
    in_valid = stall_valid;
    X = W'($urandom);
    Y = ~X;
    t = 0;
    while (!out_valid && t < 40) begin @(negedge clk); t++; end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      X = W'($urandom);
      Y = W'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_Z", int'(Z), 0);
    check("rst_idx", int'(mismatch_idx), 0);
    rst_n = 1'b1;

    // First accept on the first edge after release.
    run_op(16'hBEEF, 16'hBEEF, 0, 1'b0);
    run_op(16'h1234, 16'h1235, 0, 1'b0);
    run_op(16'h8000, 16'h0000, 0, 1'b0);
    run_op(16'hA5A5, 16'hA5A5, 0, 1'b0);

    // Stall in DONE for 5 cycles with in_valid asserted.
    run_op(16'h00F0, 16'h0000, 5, 1'b1);
    @(negedge clk);
    check("no_capture_busy", int'(busy), 0);
    check("no_capture_in_ready", int'(in_ready), 1);

    // Reset two edges into CMP discards the operation.
    in_valid = 1'b1; X = 16'h5555; Y = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hC0DE, 16'hC0DE, 0, 1'b0);

    // Randomized: equal operands or a random first mismatch position.
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = a;
      if ($urandom_range(0, 3) != 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        b = b ^ (W'($urandom_range(1, 15)) << (4 * k));
        if ($urandom_range(0, 1) == 1) b = b ^ (W'($urandom) & ~((W'(1) << (4 * k + 4)) - W'(1)));
      end
      run_op(a, b, $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eq_seq_ctrl.md
EQ_SEQ_CTRL -- requirements
Module: eq_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair on X/Y is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 The block SHALL have port X, input, 4*NIBBLES bits: operand A.
REQ-007 The block SHALL have port Y, input, 4*NIBBLES bits: operand B.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port Z, output, 1 bit: 1 means the captured X equals the captured Y.
REQ-011 The block SHALL have port mismatch_idx, output, max(1,clog2(NIBBLES)) bits: index of the first differing nibble, counted LSB-first.
REQ-012 The block SHALL have port busy, output, 1 bit: an operation is in progress (CMP state).

Function
REQ-013 The block SHALL implement a three-state machine: IDLE, CMP, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE and SHALL be 0 in CMP and DONE.
REQ-015 An in_valid&&in_ready edge SHALL register X and Y into internal operand registers, clear the nibble counter to 0 and enter CMP.
REQ-016 In CMP, each cycle SHALL compare exactly one nibble (index = counter) of the captured operands through one eq4 instance.
REQ-017 In CMP, a nibble mismatch SHALL, on that edge, set Z=0, set mismatch_idx=counter and enter DONE.
REQ-018 In CMP, a match with counter==NIBBLES-1 SHALL set Z=1, set mismatch_idx=0 and enter DONE.
REQ-019 In CMP, any other match SHALL increment the counter and remain in CMP.
REQ-020 Latency: out_valid SHALL rise m+1 edges after the accept edge for a first mismatch at nibble m, and NIBBLES edges after it when the operands are equal.
REQ-021 out_valid SHALL be 1 only in DONE; Z and mismatch_idx SHALL be registered and held stable while out_valid=1.
REQ-022 A DONE state with out_ready=1 SHALL return the block to IDLE on that edge; back-to-back operations therefore have a one-cycle IDLE bubble.
REQ-023 A DONE state with out_ready=0 SHALL remain in DONE indefinitely with all outputs held.
REQ-024 Changes on X/Y or in_valid outside an accept edge SHALL have no effect on the result in progress.
REQ-025 The block SHALL support NIBBLES=1: the result is valid after 1 edge and mismatch_idx is 1 bit, always 0.
REQ-026 busy SHALL be 1 exactly when the state is CMP.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counter=0, out_valid=0, Z=0, mismatch_idx=0, busy=0 and clear the operand registers, independent of clk.
REQ-028 While rst_n=0 and after release, in_ready SHALL be 1 (IDLE); an assertion mid-CMP or mid-DONE SHALL discard the operation with no out_valid pulse.
REQ-029 The first accept after reset release SHALL be permitted on the first rising edge with rst_n=1.

Structure
REQ-030 A shared package eq_seq_pkg SHALL hold the state typedef (IDLE=2'b00, CMP=2'b01, DONE=2'b10) and the constant NIBBLE_W=4.
REQ-031 The block SHALL instantiate the existing eq4 comparator exactly once as its only sub-module; no other comparison logic is permitted.

Verification
REQ-032 The bench SHALL cover: NIBBLES=4, X=Y=16'hBEEF -> out_valid after 4 edges, Z=1, mismatch_idx=0.
REQ-033 The bench SHALL cover: X=16'h1234, Y=16'h1235 -> out_valid after 1 edge, Z=0, mismatch_idx=0.
REQ-034 The bench SHALL cover: X=16'h8000, Y=16'h0000 -> out_valid after 4 edges, Z=0, mismatch_idx=3.
REQ-035 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE with in_valid=1 -> Z, mismatch_idx and out_valid stable, in_ready=0, and no new capture.
REQ-036 The bench SHALL cover: X/Y changed to unequal values 1 edge after accepting equal 16'hA5A5 -> Z=1.
REQ-037 The bench SHALL cover: rst_n pulsed low 2 edges into CMP -> out_valid=0 and in_ready=1 immediately, and the next operation completes normally.
